// File: rtl/sat_fifo_pkg.sv
// Shared helpers for the SAT FIFO-tree stages: depth/level width derivation and parameter legality.
package sat_fifo_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Level needs one extra bit so that a full FIFO is distinguishable from an empty one.
  function automatic int fifo_level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit fifo_params_ok(input int addr_width, input int af_thresh,
                                        input int ae_thresh);
    return (addr_width >= 1) && (addr_width <= 30) &&
           (af_thresh >= 1) && (af_thresh <= fifo_depth(addr_width)) &&
           (ae_thresh >= 0) && (ae_thresh < fifo_depth(addr_width));
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM, one write port and one read port with both a registered and an async read.
module fifo_dpram #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] adata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a same-address collision: rdata gets the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

  assign adata = mem[raddr];

endmodule

// File: rtl/fifo_buffer_thresh.sv
// Single-clock FIFO with occupancy level, programmable almost flags and sticky error flags.
// Define FIFO_BUFFER_FWFT_EN for first-word-fall-through reads; otherwise data_o is a registered read.
module fifo_buffer_thresh
  import sat_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int LW    = fifo_level_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  generate
    if (!fifo_params_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("fifo_buffer_thresh: illegal ADDR_WIDTH/AF_THRESH/AE_THRESH");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  rd_acc, wr_acc, ovf_evt, udf_evt;
  logic [DATA_WIDTH-1:0] reg_rdata, async_rdata;

  // Flags decode the registered level only.
  assign empty_o        = (level_q == '0);
  assign full_o         = (level_q == DEPTH_L);
  assign almost_empty_o = (level_q <= AE_L);
  assign almost_full_o  = (level_q >= AF_L);
  assign level_o        = level_q;

  // Flush overrides both requests and suppresses error reporting.
  assign rd_acc  = rden_i & ~empty_o & ~flush_i;
  assign wr_acc  = wren_i & (~full_o | rd_acc) & ~flush_i;
  assign ovf_evt = wren_i & ~wr_acc & ~flush_i;
  assign udf_evt = rden_i & ~rd_acc & ~flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end
  end

  // An error in the same cycle as clr_err_i keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= ovf_evt | (overflow_o & ~clr_err_i);
      underflow_o <= udf_evt | (underflow_o & ~clr_err_i);
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_i),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (reg_rdata),
    .adata (async_rdata)
  );

`ifdef FIFO_BUFFER_FWFT_EN
  logic unused_rdata;
  assign unused_rdata = ^reg_rdata;
  assign valid_o      = ~empty_o;
  assign data_o       = empty_o ? '0 : async_rdata;
`else
  logic unused_adata;
  logic valid_q;
  assign unused_adata = ^async_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else        valid_q <= rd_acc;
  end

  assign valid_o = valid_q;
  assign data_o  = reg_rdata;
`endif

endmodule
